// File: rtl/iomem_arb_pkg.sv
// Shared definitions for the iomem bus arbiter: FSM encodings and constants.
package iomem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  localparam logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF;
  localparam int          MAX_REQ      = 4;

endpackage

// File: rtl/iomem_arb_rr_pick.sv
// Combinational round-robin picker: scans from last+1 upward with wrap and
// reports whether anyone requests plus the winning index.
module rr_pick
  import iomem_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]                 req,
  input  logic [$clog2(MAX_REQ)-1:0]   last,
  output logic                         any,
  output logic [$clog2(MAX_REQ)-1:0]   idx
);

  // Walk distances from farthest to nearest so the nearest requester wins.
  always_comb begin
    any = |req;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && ((int'(last) + k) % N == i)) idx = ($clog2(MAX_REQ))'(i);
      end
    end
  end

endmodule

// File: rtl/iomem_arb.sv
// Round-robin arbiter sharing one iomem bus between N requesters.
// Optional slave watchdog enabled by defining IOMEM_ARB_TIMEOUT_EN.
module iomem_arb
  import iomem_arb_pkg::*;
#(
  parameter int N       = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              ck,
  input  logic              rst,
  input  logic [N-1:0]      req_valid,
  input  logic [32*N-1:0]   req_addr,
  input  logic [32*N-1:0]   req_wdata,
  input  logic [4*N-1:0]    req_wstrb,
  output logic [N-1:0]      req_ready,
  output logic [31:0]       req_rdata,
  output logic              m_valid,
  output logic [31:0]       m_addr,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  input  logic              m_ready,
  input  logic [31:0]       m_rdata,
  output logic              timeout
);

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d, last_q, last_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        pick_any;
  logic [1:0]  pick_idx;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_wstrb;
  logic        done;
  logic [31:0] done_data;
`ifdef IOMEM_ARB_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
`else
  wire  [39:0] unused_cfg = {8'(TIMEOUT), TIMEOUT_DATA};
`endif

  rr_pick #(.N(N)) u_pick (
    .req  (req_valid),
    .last (last_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_idx == 2'(i)) begin
        sel_addr  = req_addr[32*i +: 32];
        sel_wdata = req_wdata[32*i +: 32];
        sel_wstrb = req_wstrb[4*i +: 4];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    done      = 1'b0;
    done_data = '0;
`ifdef IOMEM_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_BUSY;
          grant_d = pick_idx;
          last_d  = pick_idx;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          wstrb_d = sel_wstrb;
`ifdef IOMEM_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_BUSY: begin
        // An ack on the count-reached cycle still completes normally.
        if (m_ready) begin
          state_d   = ST_IDLE;
          done      = 1'b1;
          done_data = m_rdata;
        end
`ifdef IOMEM_ARB_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d   = ST_ERR;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
`ifdef IOMEM_ARB_TIMEOUT_EN
      ST_ERR: begin
        state_d   = ST_IDLE;
        done      = 1'b1;
        done_data = TIMEOUT_DATA;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // A transaction being killed by reset never reports completion.
  always_comb begin
    req_ready = '0;
    req_rdata = '0;
    for (int i = 0; i < N; i++) req_ready[i] = done && !rst && (grant_q == 2'(i));
    if (done && !rst) req_rdata = done_data;
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      last_q    <= 2'(N - 1);
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
`ifdef IOMEM_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
`ifdef IOMEM_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign m_valid = (state_q == ST_BUSY);
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign m_wstrb = wstrb_q;
`ifdef IOMEM_ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_iomem_arb.sv
// Self-checking bench for iomem_arb: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_iomem_arb;
  localparam int N  = 2;
  localparam int TO = 4;

  logic            ck = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_addr, req_wdata;
  logic [4*N-1:0]  req_wstrb;
  logic [N-1:0]    req_ready;
  logic [31:0]     req_rdata;
  logic            m_valid;
  logic [31:0]     m_addr, m_wdata;
  logic [3:0]      m_wstrb;
  logic            m_ready;
  logic [31:0]     m_rdata;
  logic            timeout;

  always #5 ck = ~ck;

  iomem_arb #(.N(N), .TIMEOUT(TO)) dut (
    .ck(ck), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .req_rdata(req_rdata), .m_valid(m_valid), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_ready(m_ready),
    .m_rdata(m_rdata), .timeout(timeout)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = waiting for requests, 1 = transaction outstanding,
  // 2 = watchdog termination cycle.
  int          ph, own, last, waited;
  logic [31:0] ma, mw;
  logic [3:0]  ms;
  bit          tflag;
  bit          model_ok = 0;

  always @(negedge ck) begin
    logic [N-1:0] e_rdy;
    logic [31:0]  e_rd;
    if (model_ok) begin
      e_rdy = '0;
      e_rd  = '0;
      if (!rst && ph == 1 && m_ready) begin e_rdy = N'(1) << own; e_rd = m_rdata; end
      if (!rst && ph == 2)            begin e_rdy = N'(1) << own; e_rd = 32'hFFFF_FFFF; end
      chk("m_valid",   32'(m_valid),   32'(ph == 1));
      chk("m_addr",    m_addr,         ma);
      chk("m_wdata",   m_wdata,        mw);
      chk("m_wstrb",   32'(m_wstrb),   32'(ms));
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      chk("req_rdata", req_rdata,      e_rd);
      chk("timeout",   32'(timeout),   32'(tflag));
    end
    if (rst) begin
      ph = 0; own = 0; last = N - 1; waited = 0;
      ma = '0; mw = '0; ms = '0; tflag = 0; model_ok = 1;
    end else begin
      case (ph)
        0: begin
          for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (ph == 0 && req_valid[c]) begin
              own = c; last = c; ph = 1; waited = 0;
              ma = req_addr[32*c +: 32];
              mw = req_wdata[32*c +: 32];
              ms = req_wstrb[4*c +: 4];
            end
          end
        end
        1: begin
          if (m_ready) ph = 0;
          else begin
            waited++;
`ifdef IOMEM_ARB_TIMEOUT_EN
            if (waited == TO) begin ph = 2; tflag = 1; end
`endif
          end
        end
        default: ph = 0;
      endcase
    end
  end

  task automatic cyc();
    @(posedge ck);
    #1;
  endtask

  task automatic drain();
    req_valid = '0;
    repeat (4) begin m_ready = m_valid; cyc(); end
    m_ready = 1'b0;
  endtask

  initial begin
    int gq[$];
    int low_since, gap_bad, n;
    bit mv_prev, found;
    rst = 1'b1; req_valid = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    m_ready = 1'b0; m_rdata = '0;
    repeat (2) cyc();
    chk("rst_mvalid", 32'(m_valid), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_maddr", m_addr, 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;

    // single read by requester 0
    req_valid = 2'b01; req_addr[31:0] = 32'h0300_0010;
    cyc();
    chk("rd_mvalid", 32'(m_valid), 32'd1);
    chk("rd_maddr", m_addr, 32'h0300_0010);
    chk("rd_early_ready", 32'(req_ready), 32'd0);
    cyc();
    m_ready = 1'b1; m_rdata = 32'h1234_5678; #1;
    chk("rd_ready", 32'(req_ready), 32'b01);
    chk("rd_rdata", req_rdata, 32'h1234_5678);
    cyc();
    req_valid = '0; m_ready = 1'b0; m_rdata = '0;
    chk("rd_gap", 32'(m_valid), 32'd0);

    // contention: both hold valid, slave acks on the second BUSY cycle
    rst = 1'b1; cyc(); rst = 1'b0;
    req_valid = 2'b11; req_addr = {32'h0300_0104, 32'h0300_0100};
    low_since = 1; gap_bad = 0; mv_prev = 0;
    for (int t = 0; t < 20; t++) begin
      m_ready = m_valid && mv_prev;
      #1;
      if (req_ready != '0) begin
        gq.push_back(req_ready[1] ? 1 : 0);
        if (low_since == 0) gap_bad++;
        low_since = 0;
      end
      if (!m_valid) low_since++;
      mv_prev = m_valid;
      cyc();
    end
    chk("cont_count", 32'(gq.size()), 32'd6);
    if (gq.size() >= 4) begin
      chk("cont_g0", 32'(gq[0]), 32'd0);
      chk("cont_g1", 32'(gq[1]), 32'd1);
      chk("cont_g2", 32'(gq[2]), 32'd0);
      chk("cont_g3", 32'(gq[3]), 32'd1);
    end
    chk("cont_gap", 32'(gap_bad), 32'd0);
    drain();

    // write latch: requester 1 changes its data mid-transaction
    req_valid = 2'b10; req_addr[63:32] = 32'h0300_0200;
    req_wdata[63:32] = 32'hCAFE_F00D; req_wstrb[7:4] = 4'b0011;
    cyc();
    chk("wl_mvalid", 32'(m_valid), 32'd1);
    req_wdata[63:32] = 32'hDEAD_BEEF; req_wstrb[7:4] = 4'b1111;
    cyc();
    chk("wl_wdata", m_wdata, 32'hCAFE_F00D);
    chk("wl_wstrb", 32'(m_wstrb), 32'b0011);
    m_ready = 1'b1; #1;
    chk("wl_ready", 32'(req_ready), 32'b10);
    cyc();
    m_ready = 1'b0; req_valid = '0; req_wstrb = '0;

    // reset while a transaction is outstanding
    req_valid = 2'b01; req_addr = {32'h0300_0304, 32'h0300_0300};
    cyc();
    chk("rb_mvalid", 32'(m_valid), 32'd1);
    rst = 1'b1; m_ready = 1'b1; #1;
    chk("rb_ready_in_rst", 32'(req_ready), 32'd0);
    cyc();
    rst = 1'b0; m_ready = 1'b0; req_valid = 2'b11;
    chk("rb_mvalid_after", 32'(m_valid), 32'd0);
    chk("rb_ready_after", 32'(req_ready), 32'd0);
    cyc();
    chk("rb_first_grant", m_addr, 32'h0300_0300);
    drain();

`ifdef IOMEM_ARB_TIMEOUT_EN
    // watchdog fires on a slave that never acks
    rst = 1'b1; cyc(); rst = 1'b0;
    req_valid = 2'b10; req_addr[63:32] = 32'h0300_0400; m_ready = 1'b0;
    found = 0; n = 0;
    for (int t = 0; t < 12 && !found; t++) begin
      cyc(); n++;
      if (req_ready != '0) found = 1;
    end
    chk("to_seen", 32'(found), 32'd1);
    chk("to_latency", 32'(n), 32'd5);
    chk("to_ready", 32'(req_ready), 32'b10);
    chk("to_rdata", req_rdata, 32'hFFFF_FFFF);
    chk("to_flag", 32'(timeout), 32'd1);
    cyc();
    chk("to_sticky", 32'(timeout), 32'd1);
    m_rdata = 32'h5555_AAAA;
    cyc();
    m_ready = 1'b1; #1;
    chk("to_next_ready", 32'(req_ready), 32'b10);
    chk("to_next_rdata", req_rdata, 32'h5555_AAAA);
    cyc();
    m_ready = 1'b0; req_valid = '0;
    chk("to_still_set", 32'(timeout), 32'd1);
`else
    // without the watchdog BUSY waits indefinitely
    rst = 1'b1; cyc(); rst = 1'b0;
    req_valid = 2'b10; m_ready = 1'b0;
    repeat (10) cyc();
    chk("nto_mvalid", 32'(m_valid), 32'd1);
    chk("nto_flag", 32'(timeout), 32'd0);
    chk("nto_ready", 32'(req_ready), 32'd0);
    m_ready = 1'b1; #1;
    chk("nto_done", 32'(req_ready), 32'b10);
    cyc();
    m_ready = 1'b0; req_valid = '0;
`endif

    // ack exactly on the 4th BUSY cycle completes normally
    rst = 1'b1; cyc(); rst = 1'b0;
    req_valid = 2'b01; req_addr[31:0] = 32'h0300_0500;
    cyc();
    repeat (3) cyc();
    m_ready = 1'b1; m_rdata = 32'hA5A5_0001; #1;
    chk("bd_ready", 32'(req_ready), 32'b01);
    chk("bd_rdata", req_rdata, 32'hA5A5_0001);
    cyc();
    m_ready = 1'b0; req_valid = '0;
    chk("bd_timeout", 32'(timeout), 32'd0);
    chk("bd_mvalid", 32'(m_valid), 32'd0);

    // randomized traffic against the model
    rst = 1'b1; cyc(); rst = 1'b0;
    repeat (3000) begin
      rst       = ($urandom_range(0, 63) == 0);
      req_valid = N'($urandom);
      req_addr  = {$urandom, $urandom};
      req_wdata = {$urandom, $urandom};
      req_wstrb = 8'($urandom);
      m_ready   = ($urandom_range(0, 2) == 0);
      m_rdata   = $urandom;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
